// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, FSM state type, error classification and the
// scrub write-back payload used by the ECC scrub controller.
package ecc_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned CW_W   = DATA_W + CHK_W;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SYN_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SGL  = 2'd1,
    ERR_DBL  = 2'd2
  } err_e;

  // Scrub write-back payload: target address plus corrected codeword.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CW_W-1:0]   data;
  } scrub_req_t;

  // DBL, or ERR without SGL, is uncorrectable; SGL alone is correctable.
  function automatic err_e classify(input logic err, input logic sgl, input logic dbl);
    if (dbl || (err && !sgl)) begin
      return ERR_DBL;
    end else if (sgl) begin
      return ERR_SGL;
    end else begin
      return ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if: decoder input, read delivery and scrub write-back
// signals of the ECC scrub controller.
//   slave  : controller view (consumes dec_*, wr_ready; drives the rest)
//   master : environment view (decoder, read consumer, cache array)
interface ecc_scrub_ctrl_if;
  import ecc_pkg::*;

  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_addr;
  logic [CW_W-1:0]   dec_data;
  logic [SYN_W-1:0]  dec_syn;
  logic              dec_err;
  logic              dec_sgl;
  logic              dec_dbl;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_poison;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [CW_W-1:0]   wr_data;

  modport slave (
    input  dec_valid, dec_addr, dec_data, dec_syn, dec_err, dec_sgl, dec_dbl,
    output dec_ready,
    output rd_valid, rd_data, rd_poison,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport master (
    output dec_valid, dec_addr, dec_data, dec_syn, dec_err, dec_sgl, dec_dbl,
    input  dec_ready,
    input  rd_valid, rd_data, rd_poison,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

endinterface

// File: rtl/ecc_sat_cnt.sv
// ecc_sat_cnt: W-bit up counter with increment enable that holds at all-ones.
// Ports: clk, rst_n (sync active-low), inc (count enable), cnt (value).
module ecc_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: accepts ECC decoder results, delivers the data word (with
// poison on uncorrectable errors), writes corrected codewords back to the
// cache array, counts corrected/uncorrectable errors and raises a sticky
// uncorrectable-error interrupt.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         dec_* decoder input, rd_* delivery, wr_* scrub write
//   sgl_cnt, dbl_cnt    saturating corrected/uncorrectable counts
//   irq_dbl, irq_clr    sticky uncorrectable interrupt and its clear
//   log_* (ECC_ERR_LOG_EN only) first-error log: valid/addr/syn/dbl, log_clr
// Config macro: ECC_ERR_LOG_EN enables the first-error log.
module ecc_scrub_ctrl
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  ecc_scrub_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] sgl_cnt,
  output logic [CNT_W-1:0] dbl_cnt,
  output logic             irq_dbl,
  input  logic             irq_clr
`ifdef ECC_ERR_LOG_EN
  ,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [SYN_W-1:0]  log_syn,
  output logic              log_dbl,
  input  logic              log_clr
`endif
);

  state_e            state_q, state_d;
  logic              dec_ready_q, dec_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_poison_q, rd_poison_d;
  logic              wr_valid_q, wr_valid_d;
  scrub_req_t        wr_req_q, wr_req_d;
  logic              irq_dbl_q, irq_dbl_d;
  logic              sgl_inc;
  logic              dbl_inc;
  logic              xfer;
  err_e              err_kind;

  assign xfer     = bus.dec_valid && dec_ready_q;
  assign err_kind = classify(bus.dec_err, bus.dec_sgl, bus.dec_dbl);

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    dec_ready_d = dec_ready_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_poison_d = rd_poison_q;
    wr_valid_d  = wr_valid_q;
    wr_req_d    = wr_req_q;
    irq_dbl_d   = irq_dbl_q;
    sgl_inc     = 1'b0;
    dbl_inc     = 1'b0;

    if (xfer) begin
      rd_valid_d  = 1'b1;
      rd_data_d   = bus.dec_data[DATA_W-1:0];
      rd_poison_d = (err_kind == ERR_DBL);
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          case (err_kind)
            ERR_SGL: begin
              state_d       = SCRUB;
              wr_valid_d    = 1'b1;
              wr_req_d.addr = bus.dec_addr;
              wr_req_d.data = bus.dec_data;
              sgl_inc       = 1'b1;
            end
            ERR_DBL: dbl_inc = 1'b1;
            default: ;
          endcase
        end
      end
      SCRUB: begin
        if (wr_valid_q && bus.wr_ready) begin
          state_d    = IDLE;
          wr_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    dec_ready_d = (state_d == IDLE);

    // A new uncorrectable error beats a same-cycle clear.
    if (irq_clr) irq_dbl_d = 1'b0;
    if (dbl_inc) irq_dbl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_poison_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_req_q    <= '0;
      irq_dbl_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_ready_q <= dec_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_poison_q <= rd_poison_d;
      wr_valid_q  <= wr_valid_d;
      wr_req_q    <= wr_req_d;
      irq_dbl_q   <= irq_dbl_d;
    end
  end

  ecc_sat_cnt #(.W(CNT_W)) u_sgl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sgl_inc),
    .cnt   (sgl_cnt)
  );

  ecc_sat_cnt #(.W(CNT_W)) u_dbl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbl_inc),
    .cnt   (dbl_cnt)
  );

  assign bus.dec_ready = dec_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_poison = rd_poison_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_req_q.addr;
  assign bus.wr_data   = wr_req_q.data;
  assign irq_dbl       = irq_dbl_q;

`ifdef ECC_ERR_LOG_EN
  logic              log_valid_q, log_valid_d;
  logic [ADDR_W-1:0] log_addr_q, log_addr_d;
  logic [SYN_W-1:0]  log_syn_q, log_syn_d;
  logic              log_dbl_q, log_dbl_d;
  logic              log_cap;

  // Capture into an empty log, or upgrade a logged SGL to a DBL.
  assign log_cap = xfer && (err_kind != ERR_NONE) &&
                   (!log_valid_q || ((err_kind == ERR_DBL) && !log_dbl_q));

  always_comb begin
    log_valid_d = log_valid_q;
    log_addr_d  = log_addr_q;
    log_syn_d   = log_syn_q;
    log_dbl_d   = log_dbl_q;
    if (log_clr) log_valid_d = 1'b0;
    if (log_cap) begin
      log_valid_d = 1'b1;
      log_addr_d  = bus.dec_addr;
      log_syn_d   = bus.dec_syn;
      log_dbl_d   = (err_kind == ERR_DBL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_syn_q   <= '0;
      log_dbl_q   <= 1'b0;
    end else begin
      log_valid_q <= log_valid_d;
      log_addr_q  <= log_addr_d;
      log_syn_q   <= log_syn_d;
      log_dbl_q   <= log_dbl_d;
    end
  end

  assign log_valid = log_valid_q;
  assign log_addr  = log_addr_q;
  assign log_syn   = log_syn_q;
  assign log_dbl   = log_dbl_q;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl; also exercises a narrow ecc_sat_cnt
// instance to reach saturation quickly.
module tb_ecc_scrub_ctrl;
  import ecc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] sgl_cnt;
  logic [CNT_W-1:0] dbl_cnt;
  logic             irq_dbl;
  logic             irq_clr;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [SYN_W-1:0]  log_syn;
  logic              log_dbl;
  logic              log_clr;
  logic              sc_inc;
  logic [3:0]        sc_cnt;

  int total = 0;
  int bad   = 0;

  ecc_scrub_ctrl_if bus ();

  ecc_scrub_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sgl_cnt (sgl_cnt),
    .dbl_cnt (dbl_cnt),
    .irq_dbl (irq_dbl),
    .irq_clr (irq_clr)
`ifdef ECC_ERR_LOG_EN
    ,
    .log_valid (log_valid),
    .log_addr  (log_addr),
    .log_syn   (log_syn),
    .log_dbl   (log_dbl),
    .log_clr   (log_clr)
`endif
  );

  ecc_sat_cnt #(.W(4)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sc_inc),
    .cnt   (sc_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dec(input logic [15:0] addr, input logic [71:0] data,
                           input logic [7:0] syn, input logic err,
                           input logic sgl, input logic dbl);
    bus.dec_valid = 1'b1;
    bus.dec_addr  = addr;
    bus.dec_data  = data;
    bus.dec_syn   = syn;
    bus.dec_err   = err;
    bus.dec_sgl   = sgl;
    bus.dec_dbl   = dbl;
  endtask

  task automatic idle_dec();
    bus.dec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (bus.dec_ready !== 1'b1) begin bad++; $display("FAIL reset_dec_ready got=%0h exp=1", bus.dec_ready); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0h exp=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", bus.rd_data); end
    total++; if (bus.rd_poison !== 1'b0) begin bad++; $display("FAIL reset_rd_poison got=%0h exp=0", bus.rd_poison); end
    total++; if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%0h exp=0", bus.wr_valid); end
    total++; if (bus.wr_addr !== 16'h0) begin bad++; $display("FAIL reset_wr_addr got=%0h exp=0", bus.wr_addr); end
    total++; if (bus.wr_data !== 72'h0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", bus.wr_data); end
    total++; if (sgl_cnt !== 16'h0) begin bad++; $display("FAIL reset_sgl_cnt got=%0h exp=0", sgl_cnt); end
    total++; if (dbl_cnt !== 16'h0) begin bad++; $display("FAIL reset_dbl_cnt got=%0h exp=0", dbl_cnt); end
    total++; if (irq_dbl !== 1'b0) begin bad++; $display("FAIL reset_irq_dbl got=%0h exp=0", irq_dbl); end
    total++; if (sc_cnt !== 4'h0) begin bad++; $display("FAIL reset_sat_cnt got=%0h exp=0", sc_cnt); end
`ifdef ECC_ERR_LOG_EN
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL reset_log_valid got=%0h exp=0", log_valid); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    drive_dec(16'h0004, 72'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    idle_dec();
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL clean_rd_valid got=%0h exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL clean_rd_data got=%0h exp=0", bus.rd_data); end
    total++; if (bus.rd_poison !== 1'b0) begin bad++; $display("FAIL clean_rd_poison got=%0h exp=0", bus.rd_poison); end
    total++; if (sgl_cnt !== 16'h0 || dbl_cnt !== 16'h0) begin bad++; $display("FAIL clean_cnts got=%0h/%0h exp=0/0", sgl_cnt, dbl_cnt); end
    total++; if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL clean_wr_valid got=%0h exp=0", bus.wr_valid); end
    step();
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL clean_rd_pulse got=%0h exp=0", bus.rd_valid); end
    drive_dec(16'h0008, 72'hA5_DEADBEEF_CAFEF00D, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    idle_dec();
    total++; if (bus.rd_data !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL clean2_rd_data got=%0h exp=deadbeefcafef00d", bus.rd_data); end
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_poison !== 1'b0) begin bad++; $display("FAIL clean2_rd got=%0h/%0h exp=1/0", bus.rd_valid, bus.rd_poison); end
    step();
  endtask

  task automatic test_single();
    bus.wr_ready = 1'b0;
    drive_dec(16'h0010, 72'h0, 8'h21, 1'b1, 1'b1, 1'b0);
    step();
    // Noise on the decoder port while scrubbing must be ignored.
    drive_dec(16'h0077, 72'hFF_FFFFFFFF_FFFFFFFF, 8'hEE, 1'b1, 1'b0, 1'b1);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_poison !== 1'b0) begin bad++; $display("FAIL sgl_rd got=%0h/%0h exp=1/0", bus.rd_valid, bus.rd_poison); end
    total++; if (sgl_cnt !== 16'h1) begin bad++; $display("FAIL sgl_cnt got=%0h exp=1", sgl_cnt); end
    total++; if (bus.wr_valid !== 1'b1) begin bad++; $display("FAIL sgl_wr_valid got=%0h exp=1", bus.wr_valid); end
    total++; if (bus.dec_ready !== 1'b0) begin bad++; $display("FAIL sgl_dec_ready got=%0h exp=0", bus.dec_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 16'h0010 || bus.wr_data !== 72'h0) begin
        bad++; $display("FAIL sgl_hold%0d got=%0h/%0h/%0h exp=1/10/0", i, bus.wr_valid, bus.wr_addr, bus.wr_data); end
      total++; if (bus.dec_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
        bad++; $display("FAIL sgl_hold_rdy%0d got=%0h/%0h exp=0/0", i, bus.dec_ready, bus.rd_valid); end
      total++; if (dbl_cnt !== 16'h0 || sgl_cnt !== 16'h1) begin
        bad++; $display("FAIL sgl_hold_cnt%0d got=%0h/%0h exp=1/0", i, sgl_cnt, dbl_cnt); end
    end
    idle_dec();
    bus.wr_ready = 1'b1;
    step();
    total++; if (bus.wr_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin bad++; $display("FAIL sgl_done got=%0h/%0h exp=0/1", bus.wr_valid, bus.dec_ready); end
    drive_dec(16'h1234, 72'h5A_01234567_89ABCDEF, 8'h05, 1'b1, 1'b1, 1'b0);
    step();
    idle_dec();
    total++; if (bus.wr_data !== 72'h5A_01234567_89ABCDEF || bus.wr_addr !== 16'h1234) begin
      bad++; $display("FAIL sgl2_wr got=%0h/%0h exp=1234/5a0123456789abcdef", bus.wr_addr, bus.wr_data); end
    total++; if (bus.rd_data !== 64'h01234567_89ABCDEF || sgl_cnt !== 16'h2) begin
      bad++; $display("FAIL sgl2_rd got=%0h/%0h exp=0123456789abcdef/2", bus.rd_data, sgl_cnt); end
    step();
    total++; if (bus.wr_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin bad++; $display("FAIL sgl2_done got=%0h/%0h exp=0/1", bus.wr_valid, bus.dec_ready); end
    bus.wr_ready = 1'b0;
  endtask

  task automatic test_double();
    drive_dec(16'h0020, 72'h3, 8'h40, 1'b1, 1'b0, 1'b1);
    step();
    idle_dec();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h3) begin bad++; $display("FAIL dbl_rd got=%0h/%0h exp=1/3", bus.rd_valid, bus.rd_data); end
    total++; if (bus.rd_poison !== 1'b1) begin bad++; $display("FAIL dbl_poison got=%0h exp=1", bus.rd_poison); end
    total++; if (irq_dbl !== 1'b1) begin bad++; $display("FAIL dbl_irq got=%0h exp=1", irq_dbl); end
    total++; if (dbl_cnt !== 16'h1 || sgl_cnt !== 16'h2) begin bad++; $display("FAIL dbl_cnts got=%0h/%0h exp=1/2", dbl_cnt, sgl_cnt); end
    total++; if (bus.wr_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin bad++; $display("FAIL dbl_noscrub got=%0h/%0h exp=0/1", bus.wr_valid, bus.dec_ready); end
    step();
    total++; if (bus.wr_valid !== 1'b0 || irq_dbl !== 1'b1) begin bad++; $display("FAIL dbl_after got=%0h/%0h exp=0/1", bus.wr_valid, irq_dbl); end
  endtask

  task automatic test_irq();
    drive_dec(16'h0030, 72'h7, 8'h41, 1'b1, 1'b0, 1'b1);
    irq_clr = 1'b1;
    step();
    idle_dec();
    irq_clr = 1'b0;
    total++; if (irq_dbl !== 1'b1 || dbl_cnt !== 16'h2) begin bad++; $display("FAIL irq_setwins got=%0h/%0h exp=1/2", irq_dbl, dbl_cnt); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    total++; if (irq_dbl !== 1'b0) begin bad++; $display("FAIL irq_clr got=%0h exp=0", irq_dbl); end
    drive_dec(16'h0040, 72'h9, 8'h42, 1'b1, 1'b0, 1'b0);
    step();
    idle_dec();
    total++; if (bus.rd_poison !== 1'b1 || dbl_cnt !== 16'h3 || irq_dbl !== 1'b1) begin
      bad++; $display("FAIL erronly got=%0h/%0h/%0h exp=1/3/1", bus.rd_poison, dbl_cnt, irq_dbl); end
    total++; if (bus.wr_valid !== 1'b0 || sgl_cnt !== 16'h2) begin bad++; $display("FAIL erronly_noscrub got=%0h/%0h exp=0/2", bus.wr_valid, sgl_cnt); end
    drive_dec(16'h0044, 72'h6, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    idle_dec();
    total++; if (bus.rd_poison !== 1'b0 || irq_dbl !== 1'b1) begin bad++; $display("FAIL irq_sticky got=%0h/%0h exp=0/1", bus.rd_poison, irq_dbl); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_dec(16'h0050, 72'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    drive_dec(16'h0051, 72'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h11) begin bad++; $display("FAIL b2b_first got=%0h/%0h exp=1/11", bus.rd_valid, bus.rd_data); end
    step();
    idle_dec();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h22 || bus.dec_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/22/1", bus.rd_valid, bus.rd_data, bus.dec_ready); end
    step();
    total++; if (bus.rd_valid !== 1'b0 || sgl_cnt !== 16'h2 || dbl_cnt !== 16'h3) begin
      bad++; $display("FAIL b2b_end got=%0h/%0h/%0h exp=0/2/3", bus.rd_valid, sgl_cnt, dbl_cnt); end
  endtask

  task automatic test_reset_scrub();
    bus.wr_ready = 1'b0;
    drive_dec(16'h0060, 72'h1, 8'h43, 1'b1, 1'b0, 1'b1);
    step();
    drive_dec(16'h0061, 72'h2, 8'h07, 1'b1, 1'b1, 1'b0);
    step();
    idle_dec();
    total++; if (bus.wr_valid !== 1'b1 || dbl_cnt !== 16'h4 || irq_dbl !== 1'b1) begin
      bad++; $display("FAIL rscrub_pre got=%0h/%0h/%0h exp=1/4/1", bus.wr_valid, dbl_cnt, irq_dbl); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (bus.wr_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin bad++; $display("FAIL rscrub_wr got=%0h/%0h exp=0/1", bus.wr_valid, bus.dec_ready); end
    total++; if (sgl_cnt !== 16'h0 || dbl_cnt !== 16'h0 || irq_dbl !== 1'b0) begin
      bad++; $display("FAIL rscrub_cnt got=%0h/%0h/%0h exp=0/0/0", sgl_cnt, dbl_cnt, irq_dbl); end
    step();
    total++; if (bus.wr_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin bad++; $display("FAIL rscrub_after got=%0h/%0h exp=0/1", bus.wr_valid, bus.dec_ready); end
  endtask

  task automatic test_sat();
    sc_inc = 1'b1;
    repeat (14) step();
    total++; if (sc_cnt !== 4'hE) begin bad++; $display("FAIL sat_preload got=%0h exp=e", sc_cnt); end
    step();
    total++; if (sc_cnt !== 4'hF) begin bad++; $display("FAIL sat_max got=%0h exp=f", sc_cnt); end
    step();
    total++; if (sc_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0h exp=f", sc_cnt); end
    sc_inc = 1'b0;
  endtask

`ifdef ECC_ERR_LOG_EN
  task automatic test_log();
    bus.wr_ready = 1'b1;
    drive_dec(16'h0100, 72'h0, 8'h33, 1'b1, 1'b1, 1'b0);
    step();
    idle_dec();
    total++; if (log_valid !== 1'b1 || log_addr !== 16'h0100 || log_syn !== 8'h33 || log_dbl !== 1'b0) begin
      bad++; $display("FAIL log_sgl got=%0h/%0h/%0h/%0h exp=1/100/33/0", log_valid, log_addr, log_syn, log_dbl); end
    step();
    drive_dec(16'h0200, 72'h0, 8'h44, 1'b1, 1'b0, 1'b1);
    step();
    idle_dec();
    total++; if (log_addr !== 16'h0200 || log_dbl !== 1'b1) begin bad++; $display("FAIL log_upg got=%0h/%0h exp=200/1", log_addr, log_dbl); end
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL log_clr got=%0h exp=0", log_valid); end
    drive_dec(16'h0300, 72'h0, 8'h55, 1'b1, 1'b0, 1'b1);
    log_clr = 1'b1;
    step();
    idle_dec();
    log_clr = 1'b0;
    total++; if (log_valid !== 1'b1 || log_addr !== 16'h0300) begin bad++; $display("FAIL log_capwins got=%0h/%0h exp=1/300", log_valid, log_addr); end
    bus.wr_ready = 1'b0;
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    irq_clr       = 1'b0;
    log_clr       = 1'b0;
    sc_inc        = 1'b0;
    bus.dec_valid = 1'b0;
    bus.dec_addr  = '0;
    bus.dec_data  = '0;
    bus.dec_syn   = '0;
    bus.dec_err   = 1'b0;
    bus.dec_sgl   = 1'b0;
    bus.dec_dbl   = 1'b0;
    bus.wr_ready  = 1'b0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_irq();
    test_back_to_back();
    test_reset_scrub();
    test_sat();
`ifdef ECC_ERR_LOG_EN
    test_log();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
